tile_room_renderer: RTL and testbench
=====================================

TILE_ROOM_RENDERER -- requirements
Module: tile_room_renderer

Interface
REQ-001 The block SHALL have parameter COLS, default 20, meaning tiles per row.
REQ-002 The block SHALL have parameter ROWS, default 15, meaning tile rows.
REQ-003 The block SHALL have parameter TILE_LOG2, default 5, meaning log2 of the square tile edge in pixels (32 px).
REQ-004 The block SHALL have parameter FLOOR_COLOR, default 8'b10110110, meaning the floor pixel colour.
REQ-005 The block SHALL have port clk_vga, input, 1 bit: the pixel clock, the only clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have ports CurrentX (input, 10 bits) and CurrentY (input, 9 bits): the pixel coordinate.
REQ-008 The block SHALL have port frame_start, input, 1 bit: a one-cycle pulse at the first pixel of a frame.
REQ-009 The block SHALL have port wall, input, 8 bits: the wall colour.
REQ-010 The block SHALL have ports wr_en (input, 1 bit), wr_row (input, 4 bits) and wr_data (input, COLS bits): shadow-layout row write; bit c=1 means tile c is a wall.
REQ-011 The block SHALL have port commit, input, 1 bit: a request to swap the shadow and active layouts.
REQ-012 The block SHALL have output mapData, 8 bits: the registered pixel colour.
REQ-013 The block SHALL have output swap_pending, 1 bit: high while a committed swap awaits frame_start.
REQ-014 The block SHALL have output wr_drop, 1 bit: a one-cycle pulse when a write or commit is rejected.

Function
REQ-015 The block SHALL hold two layout banks of ROWS x COLS bits; active_sel selects the displayed bank; writes target bank ~active_sel.
REQ-016 Tile column SHALL be CurrentX>>TILE_LOG2 and tile row SHALL be CurrentY>>TILE_LOG2, by truncation with no division.
REQ-017 The pipeline SHALL have latency 2: stage 1 registers the range flag and the fetched row word; stage 2 registers mapData.
REQ-018 mapData SHALL be 8'h00 when the column is >= COLS or the row is >= ROWS; otherwise it SHALL be the wall colour when the tile bit is 1 and FLOOR_COLOR when it is 0.
REQ-019 A wr_en with wr_row < ROWS and swap_pending=0 SHALL write wr_data into the shadow row on the next edge.
REQ-020 A wr_en with wr_row >= ROWS SHALL be ignored, with no wr_drop pulse.
REQ-021 A wr_en while swap_pending=1 SHALL be dropped and SHALL pulse wr_drop.
REQ-022 The swap state machine SHALL have two states, IDLE and PENDING: IDLE goes to PENDING on commit; PENDING goes to IDLE on frame_start, toggling active_sel on that edge.
REQ-023 A commit and a frame_start in the same cycle while IDLE SHALL swap immediately, and swap_pending SHALL stay 0.
REQ-024 A commit while PENDING SHALL be ignored and SHALL pulse wr_drop.
REQ-025 A wr_en and a commit in the same cycle while IDLE SHALL perform the write first, so that the committed bank includes it.
REQ-026 A frame_start while IDLE SHALL have no effect on layout state.
REQ-027 Pixels already in the pipeline at a swap SHALL complete from the bank latched in stage 1.

Reset
REQ-028 When rst_n=0 at a clk_vga edge, the block SHALL clear both banks (all floor), set active_sel=0, enter IDLE, and drive mapData=8'h00, swap_pending=0 and wr_drop=0.
REQ-029 A reset asserted mid-PENDING SHALL cancel the pending swap.
REQ-030 A reset SHALL clear the pipeline stages, so that outputs are valid 2 cycles after reset release.

Configuration
REQ-031 With macro TILE_ROOM_FLASH_EN defined, the block SHALL add a 6-bit frame counter incremented on frame_start, and wall tiles SHALL render ~wall while counter[5]=1.
REQ-032 The frame counter SHALL wrap 63 to 0 and SHALL be reset to 0.
REQ-033 Without TILE_ROOM_FLASH_EN, the counter logic SHALL be absent and wall tiles SHALL always render wall.

Structure
REQ-034 A shared package SHALL hold the swap state enum (IDLE, PENDING), the default COLS/ROWS/TILE_LOG2 values, the FLOOR_COLOR constant and the out-of-range colour 8'h00.
REQ-035 One sub-module, tile_layout_bank, SHALL implement the double-buffered register array with its write port and a read port selected by active_sel.

Verification
REQ-036 Verification SHALL cover reset: after reset release, any X/Y -> mapData=8'hB6 from cycle 2 onward; swap_pending=0.
REQ-037 Verification SHALL cover write and swap: write row 0 = 20'h00001, commit, then frame_start; X=5,Y=5 -> mapData=wall exactly 2 cycles after the pixel is presented; X=40,Y=5 -> 8'hB6.
REQ-038 Verification SHALL cover the pending guard: commit with no frame_start, then wr_en row 3 -> wr_drop=1 for one cycle and row 3 unchanged after the swap; a second commit -> wr_drop=1.
REQ-039 Verification SHALL cover range: X=639,Y=479 -> tile (19,14) rendered; X=650 (COLS=20) -> 8'h00; wr_row=15 -> ignored with no wr_drop.
REQ-040 Verification SHALL cover simultaneous events: commit and frame_start in the same cycle -> active_sel toggles on that edge with swap_pending never 1; wr_en and commit in the same cycle -> the written row is visible after the swap.
REQ-041 Verification SHALL cover reset mid-PENDING and flash: rst_n=0 while PENDING -> swap_pending=0 with both banks floor; with TILE_ROOM_FLASH_EN, 32 frame_starts -> wall tiles render ~wall until frame 64.

Source files
------------

// File: rtl/tile_room_renderer_pkg.sv
// Shared definitions for the tile room renderer: swap state encoding,
// default geometry and the fixed colours.
package tile_room_renderer_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    localparam int         DEF_COLS        = 20;
    localparam int         DEF_ROWS        = 15;
    localparam int         DEF_TILE_LOG2   = 5;
    localparam logic [7:0] DEF_FLOOR_COLOR = 8'b10110110;
    localparam logic [7:0] OOR_COLOR       = 8'h00;

    // Index width for an n-entry table; never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_room_renderer_bank.sv
// Double-buffered tile layout store. Two banks of ROWS x COLS wall bits,
// one write port aimed at a chosen bank, one combinational read port
// aimed at the displayed bank.
module tile_layout_bank
    import tile_room_renderer_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int ROWS  = DEF_ROWS,
    parameter int ROW_W = idxWidth(ROWS)
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic             i_wr_bank,
    input  logic [ROW_W-1:0] i_wr_row,
    input  logic [COLS-1:0]  i_wr_data,
    input  logic             i_rd_sel,
    input  logic [ROW_W-1:0] i_rd_row,
    output logic [COLS-1:0]  o_rd_data
);

    logic [COLS-1:0] r_bank0 [ROWS];
    logic [COLS-1:0] r_bank1 [ROWS];

    // Clear both banks to floor on reset, otherwise store the accepted row write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                r_bank0[r] <= '0;
                r_bank1[r] <= '0;
            end
        end else if (i_wr_en) begin
            if (i_wr_bank) begin
                r_bank1[i_wr_row] <= i_wr_data;
            end else begin
                r_bank0[i_wr_row] <= i_wr_data;
            end
        end
    end

    // Read the displayed bank; rows past the table read as floor.
    always_comb begin
        o_rd_data = '0;
        if (32'(i_rd_row) < ROWS) begin
            o_rd_data = i_rd_sel ? r_bank1[i_rd_row] : r_bank0[i_rd_row];
        end
    end

endmodule

// File: rtl/tile_room_renderer.sv
// Tile room renderer: maps the current pixel to a tile, looks the tile up in
// the displayed layout bank and produces a registered colour two cycles later.
// Layout edits go to the shadow bank and are swapped in at a frame boundary.
// Optional build macro TILE_ROOM_FLASH_EN adds a frame counter that inverts
// wall colour during the upper half of every 64-frame period.
module tile_room_renderer
    import tile_room_renderer_pkg::*;
#(
    parameter int         COLS        = DEF_COLS,
    parameter int         ROWS        = DEF_ROWS,
    parameter int         TILE_LOG2   = DEF_TILE_LOG2,
    parameter logic [7:0] FLOOR_COLOR = DEF_FLOOR_COLOR
)(
    input  logic            clk_vga,
    input  logic            rst_n,
    input  logic [9:0]      CurrentX,
    input  logic [8:0]      CurrentY,
    input  logic            frame_start,
    input  logic [7:0]      wall,
    input  logic            wr_en,
    input  logic [3:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            commit,
    output logic [7:0]      mapData,
    output logic            swap_pending,
    output logic            wr_drop
);

    localparam int ROW_W = idxWidth(ROWS);
    localparam int COL_W = idxWidth(COLS);

    swap_state_t     r_state;
    swap_state_t     w_nextState;
    logic            r_activeSel;
    logic            r_wrDrop;
    logic            w_swap;
    logic            w_wrAccept;
    logic            w_wrDropNext;
    logic            w_wrRowOk;

    logic [9:0]      w_tileCol;
    logic [8:0]      w_tileRow;
    logic            w_inRange;
    logic [COLS-1:0] w_rdData;

    logic            r_s1InRange;
    logic [COLS-1:0] r_s1RowWord;
    logic [COL_W-1:0] r_s1Col;
    logic [7:0]      w_wallColor;
    logic [7:0]      r_mapData;

    assign w_tileCol = CurrentX >> TILE_LOG2;
    assign w_tileRow = CurrentY >> TILE_LOG2;
    assign w_inRange = (32'(w_tileCol) < COLS) && (32'(w_tileRow) < ROWS);
    assign w_wrRowOk = (32'(wr_row) < ROWS);

    assign mapData      = r_mapData;
    assign swap_pending = (r_state == PENDING);
    assign wr_drop      = r_wrDrop;

    // Swap control: decide next state, whether active_sel flips, and which requests are refused.
    always_comb begin
        w_nextState  = r_state;
        w_swap       = 1'b0;
        w_wrAccept   = 1'b0;
        w_wrDropNext = 1'b0;
        case (r_state)
            IDLE: begin
                w_wrAccept = wr_en && w_wrRowOk;
                if (commit) begin
                    if (frame_start) begin
                        w_swap = 1'b1;
                    end else begin
                        w_nextState = PENDING;
                    end
                end
            end
            PENDING: begin
                w_wrDropNext = (wr_en && w_wrRowOk) || commit;
                if (frame_start) begin
                    w_swap      = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Swap state register, displayed-bank select and the registered drop pulse.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_activeSel <= 1'b0;
            r_wrDrop    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_wrDrop <= w_wrDropNext;
            if (w_swap) begin
                r_activeSel <= ~r_activeSel;
            end
        end
    end

    // Writes land in the shadow bank; a same-edge swap then makes that bank visible.
    tile_layout_bank #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_bank (
        .i_clk     (clk_vga),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_wrAccept),
        .i_wr_bank (~r_activeSel),
        .i_wr_row  (ROW_W'(wr_row)),
        .i_wr_data (wr_data),
        .i_rd_sel  (r_activeSel),
        .i_rd_row  (ROW_W'(w_tileRow)),
        .o_rd_data (w_rdData)
    );

    // Stage 1: capture range flag, the fetched row word and the column within it.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_s1InRange <= 1'b0;
            r_s1RowWord <= '0;
            r_s1Col     <= '0;
        end else begin
            r_s1InRange <= w_inRange;
            r_s1RowWord <= w_rdData;
            r_s1Col     <= COL_W'(w_tileCol);
        end
    end

`ifdef TILE_ROOM_FLASH_EN
    logic [5:0] r_frameCnt;
    logic       r_s1Invert;

    // Free-running frame counter, advanced once per frame and wrapping 63 -> 0.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_frameCnt <= '0;
        end else if (frame_start) begin
            r_frameCnt <= r_frameCnt + 6'd1;
        end
    end

    // Latch the flash phase alongside the pixel so it travels with stage 1.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_s1Invert <= 1'b0;
        end else begin
            r_s1Invert <= r_frameCnt[5];
        end
    end

    assign w_wallColor = r_s1Invert ? ~wall : wall;
`else
    assign w_wallColor = wall;
`endif

    // Stage 2: pick out-of-range black, wall or floor colour for the pixel.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            r_mapData <= OOR_COLOR;
        end else if (!r_s1InRange) begin
            r_mapData <= OOR_COLOR;
        end else if (r_s1RowWord[r_s1Col]) begin
            r_mapData <= w_wallColor;
        end else begin
            r_mapData <= FLOOR_COLOR;
        end
    end

endmodule

// File: tb/tb_tile_room_renderer.sv
// Self-checking bench for tile_room_renderer. Pixel expectations go into a
// scoreboard queue when the pixel is driven and are compared when the
// two-stage pipeline delivers them; swap_pending and wr_drop are checked
// every cycle against a small behavioural model of the swap protocol.
module tb_tile_room_renderer;
    import tile_room_renderer_pkg::*;

    localparam int         COLS  = 20;
    localparam int         ROWS  = 15;
    localparam logic [7:0] FLOOR = 8'hB6;
    localparam logic [7:0] WALL  = 8'h3C;
    localparam logic [7:0] OOR   = 8'h00;

    logic            clk_vga = 1'b0;
    logic            rst_n = 1'b0;
    logic [9:0]      CurrentX = '0;
    logic [8:0]      CurrentY = '0;
    logic            frame_start = 1'b0;
    logic [7:0]      wall = WALL;
    logic            wr_en = 1'b0;
    logic [3:0]      wr_row = '0;
    logic [COLS-1:0] wr_data = '0;
    logic            commit = 1'b0;
    logic [7:0]      mapData;
    logic            swap_pending;
    logic            wr_drop;

    always #5 clk_vga = ~clk_vga;

    tile_room_renderer #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .TILE_LOG2   (5),
        .FLOOR_COLOR (8'b10110110)
    ) dut (
        .clk_vga      (clk_vga),
        .rst_n        (rst_n),
        .CurrentX     (CurrentX),
        .CurrentY     (CurrentY),
        .frame_start  (frame_start),
        .wall         (wall),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .commit       (commit),
        .mapData      (mapData),
        .swap_pending (swap_pending),
        .wr_drop      (wr_drop)
    );

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        string      name;
    } sb_t;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic [7:0] exp;
        string      name;
    } vec_t;

    sb_t  sbQ[$];
    int   compared = 0;
    int   mismatched = 0;

    logic mPending = 1'b0;
    logic mDrop = 1'b0;
    int   mFrames = 0;

    vec_t tblFloor[6];
    vec_t tblRoom[10];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] wallExp();
`ifdef TILE_ROOM_FLASH_EN
        return (mFrames >= 32) ? ~WALL : WALL;
`else
        return WALL;
`endif
    endfunction

    // Advance the swap-protocol model by the events driven for this edge.
    task automatic stepModel();
        logic oldP;
        bit   rowOk;
        oldP  = mPending;
        rowOk = (int'(wr_row) < ROWS);
        mDrop = 1'b0;
        if (oldP && ((wr_en && rowOk) || commit)) mDrop = 1'b1;
        if (!oldP && commit && !frame_start) mPending = 1'b1;
        if (oldP && frame_start) mPending = 1'b0;
        if (frame_start) mFrames = (mFrames + 1) % 64;
    endtask

    // Drive one pixel for one cycle together with whatever strobes are set.
    task automatic applyStimulus(input logic [9:0] x, input logic [8:0] y,
                                 input bit chk, input logic [7:0] exp, input string name);
        sb_t e;
        CurrentX = x;
        CurrentY = y;
        sbQ.push_back('{chk, exp, name});
        stepModel();
        @(posedge clk_vga);
        #1;
        checkOutput({name, "/swap_pending"}, 32'(swap_pending), 32'(mPending));
        checkOutput({name, "/wr_drop"}, 32'(wr_drop), 32'(mDrop));
        if (sbQ.size() >= 2) begin
            e = sbQ.pop_front();
            if (e.chk) checkOutput(e.name, 32'(mapData), 32'(e.exp));
        end
        wr_en       = 1'b0;
        commit      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(10'd0, 9'd0, 1'b0, OOR, "idle");
    endtask

    task automatic resetDut();
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        commit      = 1'b0;
        frame_start = 1'b0;
        sbQ.delete();
        repeat (2) @(posedge clk_vga);
        #1;
        mPending = 1'b0;
        mDrop    = 1'b0;
        mFrames  = 0;
        checkOutput("reset/mapData", 32'(mapData), 32'(OOR));
        checkOutput("reset/swap_pending", 32'(swap_pending), 32'd0);
        checkOutput("reset/wr_drop", 32'(wr_drop), 32'd0);
        rst_n = 1'b1;
        sbQ.push_back('{1'b1, OOR, "release/first_cycle"});
    endtask

    initial begin
        tblFloor[0] = '{10'd0,    9'd0,   FLOOR, "floor/origin"};
        tblFloor[1] = '{10'd639,  9'd479, FLOOR, "floor/last_tile"};
        tblFloor[2] = '{10'd320,  9'd240, FLOOR, "floor/centre"};
        tblFloor[3] = '{10'd650,  9'd10,  OOR,   "floor/col_oor"};
        tblFloor[4] = '{10'd100,  9'd480, OOR,   "floor/row_oor"};
        tblFloor[5] = '{10'd1023, 9'd511, OOR,   "floor/corner_oor"};

        tblRoom[0] = '{10'd5,   9'd5,   WALL,  "room/tile0_0"};
        tblRoom[1] = '{10'd31,  9'd31,  WALL,  "room/tile0_0_edge"};
        tblRoom[2] = '{10'd32,  9'd0,   FLOOR, "room/tile1_0"};
        tblRoom[3] = '{10'd40,  9'd5,   FLOOR, "room/x40"};
        tblRoom[4] = '{10'd639, 9'd479, WALL,  "room/tile19_14"};
        tblRoom[5] = '{10'd608, 9'd448, WALL,  "room/tile19_14_org"};
        tblRoom[6] = '{10'd607, 9'd479, FLOOR, "room/tile18_14"};
        tblRoom[7] = '{10'd639, 9'd447, FLOOR, "room/tile19_13"};
        tblRoom[8] = '{10'd650, 9'd5,   OOR,   "room/x650"};
        tblRoom[9] = '{10'd5,   9'd480, OOR,   "room/y480"};

        $display("[TB] reset and all-floor sweep");
        resetDut();
        foreach (tblFloor[i]) applyStimulus(tblFloor[i].x, tblFloor[i].y, 1'b1, tblFloor[i].exp, tblFloor[i].name);
        idle(2);

        $display("[TB] write row 0, commit, then frame_start");
        wr_en = 1'b1; wr_row = 4'd0; wr_data = 20'h00001;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "A/write");
        commit = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "A/commit");
        idle(2);
        frame_start = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "A/frame_start");
        applyStimulus(10'd5,  9'd5, 1'b1, wallExp(), "A/x5y5");
        applyStimulus(10'd40, 9'd5, 1'b1, FLOOR,     "A/x40y5");
        applyStimulus(10'd5,  9'd5, 1'b1, wallExp(), "A/x5y5_again");
        idle(2);

        $display("[TB] write plus commit in the same cycle");
        wr_en = 1'b1; wr_row = 4'd0; wr_data = 20'h00001;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "B/write_row0");
        wr_en = 1'b1; wr_row = 4'd14; wr_data = 20'h80000; commit = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "B/write_row14_commit");
        idle(1);
        frame_start = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "B/frame_start");
        foreach (tblRoom[i]) applyStimulus(tblRoom[i].x, tblRoom[i].y, 1'b1, tblRoom[i].exp, tblRoom[i].name);
        idle(2);

        $display("[TB] pending guard");
        commit = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "C/commit");
        wr_en = 1'b1; wr_row = 4'd3; wr_data = 20'hFFFFF;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "C/write_while_pending");
        idle(1);
        commit = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "C/second_commit");
        idle(1);
        frame_start = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "C/frame_start");
        applyStimulus(10'd5,   9'd100, 1'b1, FLOOR, "C/row3_unchanged");
        applyStimulus(10'd5,   9'd5,   1'b1, WALL,  "C/row0_wall");
        applyStimulus(10'd639, 9'd479, 1'b1, FLOOR, "C/row14_floor");
        idle(2);

        $display("[TB] commit and frame_start together");
        commit = 1'b1; frame_start = 1'b1;
        applyStimulus(10'd639, 9'd479, 1'b1, FLOOR, "D/inflight_old_bank");
        applyStimulus(10'd639, 9'd479, 1'b1, WALL,  "D/new_bank");
        idle(2);

        $display("[TB] out-of-range write row");
        wr_en = 1'b1; wr_row = 4'd15; wr_data = 20'hFFFFF;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "E/row15_write");
        applyStimulus(10'd5,   9'd5,   1'b1, WALL, "E/row0_intact");
        applyStimulus(10'd639, 9'd479, 1'b1, WALL, "E/row14_intact");
        idle(2);

        $display("[TB] reset while pending");
        wr_en = 1'b1; wr_row = 4'd5; wr_data = 20'hFFFFF;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "F/write_row5");
        commit = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "F/commit");
        resetDut();
        frame_start = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "F/frame_start");
        applyStimulus(10'd5,   9'd170, 1'b1, FLOOR, "F/row5_floor");
        applyStimulus(10'd5,   9'd5,   1'b1, FLOOR, "F/row0_floor");
        applyStimulus(10'd639, 9'd479, 1'b1, FLOOR, "F/row14_floor");
        idle(2);

`ifdef TILE_ROOM_FLASH_EN
        $display("[TB] wall flash over frame counter");
        wr_en = 1'b1; wr_row = 4'd0; wr_data = 20'h00001; commit = 1'b1; frame_start = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "G/write_swap");
        applyStimulus(10'd5, 9'd5, 1'b1, WALL, "G/before_flash");
        for (int i = mFrames; i < 32; i++) begin
            frame_start = 1'b1;
            applyStimulus(10'd0, 9'd0, 1'b0, OOR, "G/frame");
        end
        applyStimulus(10'd5,  9'd5, 1'b1, ~WALL, "G/flash_on");
        applyStimulus(10'd40, 9'd5, 1'b1, FLOOR, "G/floor_steady");
        for (int i = mFrames; i < 63; i++) begin
            frame_start = 1'b1;
            applyStimulus(10'd0, 9'd0, 1'b0, OOR, "G/frame");
        end
        applyStimulus(10'd5, 9'd5, 1'b1, ~WALL, "G/frame63");
        frame_start = 1'b1;
        applyStimulus(10'd0, 9'd0, 1'b0, OOR, "G/wrap");
        applyStimulus(10'd5, 9'd5, 1'b1, WALL, "G/after_wrap");
        idle(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
